// File: rtl/coffee_button_debounce.sv
// Panel push-button conditioner: two-flop synchroniser, stability-counter debounce FSM,
// registered level, press/release strobes and a wrapping press counter.
module coffee_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic [7:0] press_cnt
);

  localparam logic             INACTIVE = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic             sync1;
  logic             sync2;
  logic             pressed;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             level_n;
  logic             press_n;
  logic             release_n;
  logic [7:0]       press_cnt_n;

  // Synchroniser idles at the un-pressed pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= INACTIVE;
      sync2 <= INACTIVE;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ INACTIVE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_cnt   <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
      press_cnt   <= press_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    level_n     = btn_level;
    press_n     = 1'b0;
    release_n   = 1'b0;
    press_cnt_n = press_cnt;
    case (state)
      RELEASED: begin
        cnt_n = '0;
        if (pressed) state_n = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n     = PRESSED;
          cnt_n       = '0;
          level_n     = 1'b1;
          press_n     = 1'b1;
          press_cnt_n = press_cnt + 8'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        cnt_n = '0;
        if (!pressed) state_n = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n   = RELEASED;
          cnt_n     = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
